// File: rtl/nic_pkg.sv
// Shared defaults and state encoding for the NIC transmit path.
package nic_pkg;
    localparam int unsigned NIC_DATA_W = 64;
    localparam int unsigned NIC_DEPTH  = 4;
    localparam int unsigned NIC_CNT_W  = 16;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } nic_state_e;
endpackage

// File: rtl/nic_fifo.sv
// Show-ahead synchronous FIFO; pointers wrap naturally, count is one bit wider.
module nic_fifo #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [DATA_W-1:0]          i_din,
    output logic [DATA_W-1:0]          o_head,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CW    = PTR_W + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CW-1:0]     r_count;

    // Storage has no reset; validity is tracked by the count.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
endmodule

// File: rtl/nic_injector.sv
// PE-to-router injector: FIFO plus one output register driving send/ready.
module nic_injector
    import nic_pkg::*;
#(
    parameter int unsigned DATA_W = NIC_DATA_W,
    parameter int unsigned DEPTH  = NIC_DEPTH,
    parameter int unsigned CNT_W  = NIC_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              nic_en,
    input  logic              pe_we,
    input  logic [DATA_W-1:0] pe_di,
    output logic              pe_full,
    output logic              pe_ovf,
    output logic              nic_so,
    output logic [DATA_W-1:0] nic_do,
    input  logic              nic_ro,
    output logic [CNT_W-1:0]  tx_count
);
    localparam int unsigned FCW = $clog2(DEPTH) + 1;

    nic_state_e        r_state;
    nic_state_e        w_next_state;
    logic [DATA_W-1:0] r_data;
    logic              r_ovf;
    logic [CNT_W-1:0]  r_tx_count;

    logic [DATA_W-1:0] w_fifo_head;
    logic [FCW-1:0]    w_fifo_count;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic              w_accept;
    logic              w_load;
    logic              w_bypass;
    logic              w_pop;
    logic              w_push;

    nic_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (pe_di),
        .o_head  (w_fifo_head),
        .o_count (w_fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Register loads when empty or being drained; FIFO head beats the bypass path.
    always_comb begin
        w_next_state = r_state;
        w_accept     = (r_state == SEND) && nic_ro;
        w_load       = nic_en && ((w_fifo_count != '0) || pe_we)
                       && ((r_state == IDLE) || w_accept);
        w_bypass     = w_load && w_fifo_empty;
        w_pop        = w_load && !w_fifo_empty;
        w_push       = pe_we && !w_fifo_full && !w_bypass;
        case (r_state)
            IDLE:    if (w_load) w_next_state = SEND;
            SEND:    if (w_accept && !w_load) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data     <= '0;
            r_ovf      <= 1'b0;
            r_tx_count <= '0;
        end else begin
            if (w_load) begin
                r_data <= w_bypass ? pe_di : w_fifo_head;
            end
            if (pe_we && w_fifo_full) begin
                r_ovf <= 1'b1;
            end
            if (w_accept) begin
                r_tx_count <= r_tx_count + CNT_W'(1);
            end
        end
    end

    assign nic_so   = (r_state == SEND);
    assign nic_do   = r_data;
    assign pe_ovf   = r_ovf;
    assign pe_full  = w_fifo_full;
    assign tx_count = r_tx_count;
endmodule

// File: tb/tb_nic_injector.sv
// Self-checking bench for nic_injector against a queue-based transfer model.
module tb_nic_injector;
    localparam int unsigned DW    = 64;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          nic_en;
    logic          pe_we;
    logic [DW-1:0] pe_di;
    logic          pe_full;
    logic          pe_ovf;
    logic          nic_so;
    logic [DW-1:0] nic_do;
    logic          nic_ro;
    logic [CW-1:0] tx_count;

    int errors = 0;
    int checks = 0;

    // Model: one output slot plus a bounded queue, described by transfer rules only.
    bit            m_valid;
    logic [DW-1:0] m_data;
    logic [DW-1:0] m_q[$];
    bit            m_ovf;
    int            m_cnt;

    always #5 clk = ~clk;

    nic_injector #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk      (clk),
        .reset    (reset),
        .nic_en   (nic_en),
        .pe_we    (pe_we),
        .pe_di    (pe_di),
        .pe_full  (pe_full),
        .pe_ovf   (pe_ovf),
        .nic_so   (nic_so),
        .nic_do   (nic_do),
        .nic_ro   (nic_ro),
        .tx_count (tx_count)
    );

    task automatic model_edge();
        bit was_full;
        bit can_load;
        bit acc;
        acc      = m_valid && nic_ro;
        was_full = (m_q.size() == DEPTH);
        can_load = nic_en && (!m_valid || acc);
        if (acc) m_cnt = (m_cnt + 1) % (1 << CW);
        if (pe_we && was_full) m_ovf = 1'b1;
        if (can_load && m_q.size() > 0) begin
            m_data = m_q.pop_front();
            m_valid = 1'b1;
            if (pe_we && !was_full) m_q.push_back(pe_di);
        end else if (can_load && pe_we) begin
            m_data = pe_di;
            m_valid = 1'b1;
        end else begin
            if (acc) m_valid = 1'b0;
            if (pe_we && !was_full) m_q.push_back(pe_di);
        end
    endtask

    task automatic step(input bit en, input bit we, input logic [DW-1:0] di, input bit ro);
        nic_en = en; pe_we = we; pe_di = di; nic_ro = ro;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; pe_we = 1'b0; nic_en = 1'b0; nic_ro = 1'b0;
        @(posedge clk);
        m_valid = 1'b0; m_data = '0; m_q.delete(); m_ovf = 1'b0; m_cnt = 0;
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (nic_so !== 1'b0)  begin errors++; $display("FAIL reset_so: got %b want 0", nic_so); end
        checks++; if (nic_do !== '0)    begin errors++; $display("FAIL reset_do: got %h want 0", nic_do); end
        checks++; if (pe_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", pe_full); end
        checks++; if (pe_ovf !== 1'b0)  begin errors++; $display("FAIL reset_ovf: got %b want 0", pe_ovf); end
        checks++; if (tx_count !== '0)  begin errors++; $display("FAIL reset_cnt: got %0d want 0", tx_count); end
    endtask

    task automatic test_single();
        logic [DW-1:0] v;
        v = 64'hA5A5_0000_0000_0001;
        do_reset();
        step(1, 1, v, 1);
        checks++; if (nic_so !== 1'b1) begin errors++; $display("FAIL single_so: got %b want 1", nic_so); end
        checks++; if (nic_do !== v)    begin errors++; $display("FAIL single_do: got %h want %h", nic_do, v); end
        step(1, 0, '0, 1);
        checks++; if (nic_so !== 1'b0)    begin errors++; $display("FAIL single_so_after: got %b want 0", nic_so); end
        checks++; if (tx_count !== CW'(1)) begin errors++; $display("FAIL single_cnt: got %0d want 1", tx_count); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            step(1, 1, DW'(i), 1);
            checks++;
            if (nic_so !== 1'b1 || nic_do !== DW'(i)) begin
                errors++; $display("FAIL b2b_flit%0d: got so=%b do=%h want so=1 do=%h", i, nic_so, nic_do, DW'(i));
            end
        end
        step(1, 0, '0, 1);
        checks++; if (nic_so !== 1'b0)     begin errors++; $display("FAIL b2b_idle: got %b want 0", nic_so); end
        checks++; if (tx_count !== CW'(8)) begin errors++; $display("FAIL b2b_cnt: got %0d want 8", tx_count); end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            step(1, 1, DW'(k), 0);
            checks++;
            if (pe_full !== (k >= 5)) begin errors++; $display("FAIL bp_full_w%0d: got %b want %b", k, pe_full, (k >= 5)); end
            checks++;
            if (pe_ovf !== (k == 6)) begin errors++; $display("FAIL bp_ovf_w%0d: got %b want %b", k, pe_ovf, (k == 6)); end
        end
        checks++; if (nic_do !== DW'(1)) begin errors++; $display("FAIL bp_head: got %h want 1", nic_do); end
        for (int j = 1; j <= 5; j++) begin
            step(1, 0, '0, 1);
            checks++;
            if (j < 5 && (nic_so !== 1'b1 || nic_do !== DW'(j + 1))) begin
                errors++; $display("FAIL bp_drain%0d: got so=%b do=%h want so=1 do=%h", j, nic_so, nic_do, DW'(j + 1));
            end else if (j == 5 && nic_so !== 1'b0) begin
                errors++; $display("FAIL bp_drain_end: got so=%b want 0", nic_so);
            end
        end
        checks++; if (tx_count !== CW'(5)) begin errors++; $display("FAIL bp_cnt: got %0d want 5", tx_count); end
        checks++; if (pe_ovf !== 1'b1)     begin errors++; $display("FAIL bp_ovf_sticky: got %b want 1", pe_ovf); end
    endtask

    task automatic test_en_hold();
        logic [DW-1:0] x;
        logic [DW-1:0] y;
        x = 64'h1111_2222_3333_4444;
        y = 64'h5555_6666_7777_8888;
        do_reset();
        step(1, 1, x, 0);
        step(0, 1, y, 0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (nic_so !== 1'b1 || nic_do !== x) begin
                errors++; $display("FAIL hold_stable%0d: got so=%b do=%h want so=1 do=%h", i, nic_so, nic_do, x);
            end
            step(0, 0, '0, 0);
        end
        step(0, 0, '0, 1);
        checks++; if (nic_so !== 1'b0)     begin errors++; $display("FAIL hold_accept: got so=%b want 0", nic_so); end
        checks++; if (tx_count !== CW'(1)) begin errors++; $display("FAIL hold_cnt: got %0d want 1", tx_count); end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, '0, 1);
            checks++; if (nic_so !== 1'b0) begin errors++; $display("FAIL hold_noload%0d: got so=%b want 0", i, nic_so); end
        end
        step(1, 0, '0, 1);
        checks++;
        if (nic_so !== 1'b1 || nic_do !== y) begin
            errors++; $display("FAIL hold_resume: got so=%b do=%h want so=1 do=%h", nic_so, nic_do, y);
        end
    endtask

    task automatic test_push_pop();
        do_reset();
        step(1, 1, DW'(10), 0);
        step(1, 1, DW'(11), 0);
        step(1, 1, DW'(12), 0);
        step(1, 1, DW'(13), 1);
        checks++;
        if (dut.u_fifo.o_count !== 3'd2) begin errors++; $display("FAIL pp_count: got %0d want 2", dut.u_fifo.o_count); end
        checks++; if (nic_do !== DW'(11)) begin errors++; $display("FAIL pp_head: got %h want 11", nic_do); end
        for (int j = 12; j <= 13; j++) begin
            step(1, 0, '0, 1);
            checks++;
            if (nic_so !== 1'b1 || nic_do !== DW'(j)) begin
                errors++; $display("FAIL pp_order%0d: got so=%b do=%h want so=1 do=%h", j, nic_so, nic_do, DW'(j));
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 1; i <= 17; i++) step(1, 1, DW'(i), 1);
        step(1, 0, '0, 1);
        checks++; if (tx_count !== CW'(1)) begin errors++; $display("FAIL wrap_cnt: got %0d want 1", tx_count); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 1; i <= 4; i++) step(1, 1, DW'(i + 40), 0);
        do_reset();
        checks++; if (nic_so !== 1'b0)  begin errors++; $display("FAIL rmid_so: got %b want 0", nic_so); end
        checks++; if (pe_full !== 1'b0) begin errors++; $display("FAIL rmid_full: got %b want 0", pe_full); end
        checks++; if (pe_ovf !== 1'b0)  begin errors++; $display("FAIL rmid_ovf: got %b want 0", pe_ovf); end
        checks++; if (tx_count !== '0)  begin errors++; $display("FAIL rmid_cnt: got %0d want 0", tx_count); end
        for (int i = 0; i < 6; i++) begin
            step(1, 0, '0, 1);
            checks++; if (nic_so !== 1'b0) begin errors++; $display("FAIL rmid_stale%0d: got so=%b want 0", i, nic_so); end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                     {$urandom, $urandom}, $urandom_range(0, 2) != 0);
            end
            checks++;
            if (nic_so !== m_valid || (m_valid && nic_do !== m_data) || pe_full !== (m_q.size() == DEPTH)
                || pe_ovf !== m_ovf || tx_count !== CW'(m_cnt)) begin
                errors++;
                $display("FAIL rand_c%0d: got so=%b do=%h full=%b ovf=%b cnt=%0d want so=%b do=%h full=%b ovf=%b cnt=%0d",
                         c, nic_so, nic_do, pe_full, pe_ovf, tx_count,
                         m_valid, m_data, (m_q.size() == DEPTH), m_ovf, m_cnt);
            end
        end
    endtask

    initial begin
        reset = 1'b1; nic_en = 1'b0; pe_we = 1'b0; pe_di = '0; nic_ro = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_en_hold();
        test_push_pop();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
